ship_life_ctrl: RTL

Game-flow controller that sequences the player spaceship: start, lives, death delay, respawn and post-respawn invulnerability, pause and game-over. It sits between the keyboard keycode bus and the ship movement/collision block. It consumes that block's collision output and drives its position-reset, motion-enable and collision-enable controls. The renderer reads the visibility and state outputs.

---
 rtl/ship_life_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ship_life_ctrl.sv
// Player-ship game-flow controller: start, lives, death delay, respawn,
// post-respawn invulnerability, pause and game-over sequencing.
module ship_life_ctrl #(
    parameter int unsigned LIVES          = 3,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned INVULN_FRAMES  = 120
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [23:0] keycode,
    input  logic        hit_in,
    output logic        ship_reset,
    output logic        ship_enable,
    output logic        collide_en,
    output logic        ship_visible,
    output logic [3:0]  lives,
    output logic [2:0]  game_state,
    output logic        game_over
);

    localparam int unsigned KEY_W   = 8;
    localparam int unsigned TIMER_W = 8;
    localparam int unsigned LIVES_W = 4;
    localparam int unsigned STATE_W = 3;

    localparam logic [KEY_W-1:0] KEY_START = 8'h28;
    localparam logic [KEY_W-1:0] KEY_PAUSE = 8'h13;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_DYING  = 3'd2,
        ST_INVULN = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    state_t               state_q, state_d, ret_q, ret_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 start_prev_q, pause_prev_q;
    logic                 pulse_d;
    logic                 enable_d, collide_d, visible_d, over_d;

    logic start_now_c, pause_now_c, start_press_c, pause_press_c;

    // Key presence in any slot, and rising-edge press detection
    assign start_now_c = (keycode[23:16] == KEY_START) || (keycode[15:8] == KEY_START) ||
                         (keycode[7:0] == KEY_START);
    assign pause_now_c = (keycode[23:16] == KEY_PAUSE) || (keycode[15:8] == KEY_PAUSE) ||
                         (keycode[7:0] == KEY_PAUSE);
    assign start_press_c = start_now_c && !start_prev_q;
    assign pause_press_c = pause_now_c && !pause_prev_q;

    // State and output registers
    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_PLAY;
            lives_q      <= LIVES_W'(LIVES);
            timer_q      <= '0;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            ship_reset   <= 1'b0;
            ship_enable  <= 1'b0;
            collide_en   <= 1'b0;
            ship_visible <= 1'b1;
            game_over    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            lives_q      <= lives_d;
            timer_q      <= timer_d;
            start_prev_q <= start_now_c;
            pause_prev_q <= pause_now_c;
            ship_reset   <= pulse_d;
            ship_enable  <= enable_d;
            collide_en   <= collide_d;
            ship_visible <= visible_d;
            game_over    <= over_d;
        end
    end

    // Next-state, lives, timer and respawn-pulse logic
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        lives_d = lives_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_press_c) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_W'(LIVES);
                    pulse_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (hit_in) begin
                    if (lives_q > LIVES_W'(1)) begin
                        state_d = ST_DYING;
                        lives_d = lives_q - LIVES_W'(1);
                        timer_d = TIMER_W'(RESPAWN_FRAMES - 1);
                    end else begin
                        state_d = ST_OVER;
                        lives_d = '0;
                    end
                end else if (pause_press_c) begin
                    state_d = ST_PAUSE;
                    ret_d   = ST_PLAY;
                end
            end
            ST_DYING: begin
                if (timer_q == '0) begin
                    state_d = ST_INVULN;
                    pulse_d = 1'b1;
                    timer_d = TIMER_W'(INVULN_FRAMES - 1);
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_INVULN: begin
                if (pause_press_c) begin
                    state_d = ST_PAUSE;
                    ret_d   = ST_INVULN;
                end else if (timer_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_PAUSE: begin
                if (pause_press_c) begin
                    state_d = ret_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state; INVULN blinks on timer bit 3
    always_comb begin
        enable_d  = 1'b0;
        collide_d = 1'b0;
        visible_d = 1'b1;
        over_d    = 1'b0;
        case (state_d)
            ST_PLAY: begin
                enable_d  = 1'b1;
                collide_d = 1'b1;
            end
            ST_DYING:  visible_d = 1'b0;
            ST_INVULN: begin
                enable_d  = 1'b1;
                visible_d = ~timer_d[3];
            end
            ST_OVER: begin
                visible_d = 1'b0;
                over_d    = 1'b1;
            end
            default: ;
        endcase
    end

    assign lives      = lives_q;
    assign game_state = state_q;

endmodule
